hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 32 +++
 rtl/hazard_ctrl_match.sv | 14 +
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: FSM states, forward-select codes,
// and the in-flight slot record.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Drain timer is a down-counter loaded on ebreak issue; terminal count is 0.
  localparam logic [1:0] DRAIN_LOAD = 2'd2;

  typedef struct packed {
    logic       valid;
    logic       wen;
    logic [4:0] rd;
    logic       is_load;
  } slot_t;

  // The producer one stage ahead wins, since it holds the younger value.
  function automatic logic [1:0] fwd_code(input logic ex_hit, input logic mem_hit);
    if (ex_hit)       return FWD_MEM;
    else if (mem_hit) return FWD_WB;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_match.sv
// Compares one in-flight slot's destination against one ID source operand.
module hazard_match (
  input  logic       valid_i,
  input  logic       wen_i,
  input  logic [4:0] rd_i,
  input  logic [4:0] rs_i,
  input  logic       use_rs_i,
  output logic       match_o
);

  // x0 is hardwired zero, so a write to it never produces a dependency.
  assign match_o = valid_i & wen_i & (rd_i != 5'd0) & (rd_i == rs_i) & use_rs_i;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/bubble, operand forwarding and ebreak halt.
// Build option HAZARD_FORWARD_EN enables forwarding; without it every EX/MEM dependency stalls.
//
// state | meaning
// RUN   | normal issue; hazards stall ID
// DRAIN | ebreak issued; three cycles to let older instructions retire
// HALT  | pipeline frozen until reset
import hazard_ctrl_pkg::*;

module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             id_valid,
  input  logic             id_wen,
  input  logic [4:0]       id_rd,
  input  logic             id_is_load,
  input  logic             id_is_branch,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_pc_sel,
  input  logic             id_ebreak,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  slot_t            ex_q, mem_q, wb_q, ex_d;
  state_e           state_q, state_d;
  logic [1:0]       drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             ex_m1, ex_m2, mem_m1, mem_m2;
  logic             hazard, issue;

  hazard_match u_ex_rs1  (.valid_i(ex_q.valid),  .wen_i(ex_q.wen),  .rd_i(ex_q.rd),
                          .rs_i(id_rs1), .use_rs_i(id_use_rs1), .match_o(ex_m1));
  hazard_match u_ex_rs2  (.valid_i(ex_q.valid),  .wen_i(ex_q.wen),  .rd_i(ex_q.rd),
                          .rs_i(id_rs2), .use_rs_i(id_use_rs2), .match_o(ex_m2));
  hazard_match u_mem_rs1 (.valid_i(mem_q.valid), .wen_i(mem_q.wen), .rd_i(mem_q.rd),
                          .rs_i(id_rs1), .use_rs_i(id_use_rs1), .match_o(mem_m1));
  hazard_match u_mem_rs2 (.valid_i(mem_q.valid), .wen_i(mem_q.wen), .rd_i(mem_q.rd),
                          .rs_i(id_rs2), .use_rs_i(id_use_rs2), .match_o(mem_m2));

  // WB never hazards (regfile writes before read); the slot is tracked but not consulted.
  logic unused_slots;

`ifdef HAZARD_FORWARD_EN
  assign hazard = id_valid & ((id_is_branch & (ex_m1 | ex_m2 | mem_m1 | mem_m2))
                            | (ex_q.is_load & (ex_m1 | ex_m2)));
  assign unused_slots = ^{wb_q, mem_q.is_load};

  logic [1:0] fwd_a_q, fwd_b_q;
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= issue ? fwd_code(ex_m1, mem_m1) : FWD_RF;
      fwd_b_q <= issue ? fwd_code(ex_m2, mem_m2) : FWD_RF;
    end
  end
  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
`else
  assign hazard       = id_valid & (ex_m1 | ex_m2 | mem_m1 | mem_m2);
  assign unused_slots = ^{wb_q, mem_q.is_load, ex_q.is_load};
  assign fwd_a_sel    = FWD_RF;
  assign fwd_b_sel    = FWD_RF;
`endif

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    issue     = 1'b0;
    stall_if  = 1'b1;
    stall_id  = 1'b1;
    bubble_ex = 1'b1;
    flush_id  = 1'b0;
    halted    = 1'b0;
    case (state_q)
      ST_RUN: begin
        issue     = id_valid & ~hazard;
        stall_if  = hazard;
        stall_id  = hazard;
        bubble_ex = hazard;
        flush_id  = issue & id_pc_sel;
        if (issue & id_ebreak) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 2'd0) state_d = ST_HALT;
        else                 drain_d = drain_q - 2'd1;
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_RUN;
    endcase
  end

  assign ex_d = issue ? {1'b1, id_wen, id_rd, id_is_load} : '0;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_RUN;
      drain_q <= 2'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
      if ((state_q == ST_RUN) && hazard && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a cycle-age reference model predicts outputs,
// a monitor on the falling edge pops and compares.
module tb_hazard_ctrl;

  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          id_valid, id_wen, id_is_load, id_is_branch;
  logic [4:0]    id_rd, id_rs1, id_rs2;
  logic          id_use_rs1, id_use_rs2, id_pc_sel, id_ebreak;
  logic          stall_if, stall_id, flush_id, bubble_ex, halted;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cnt;

  always #5 sys_clk = ~sys_clk;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .id_valid(id_valid), .id_wen(id_wen), .id_rd(id_rd), .id_is_load(id_is_load),
    .id_is_branch(id_is_branch), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_pc_sel(id_pc_sel),
    .id_ebreak(id_ebreak), .stall_if(stall_if), .stall_id(stall_id),
    .flush_id(flush_id), .bubble_ex(bubble_ex), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .halted(halted), .stall_cnt(stall_cnt)
  );

  typedef struct {
    bit v; bit wen; int rd; bit load; bit br;
    int rs1; int rs2; bit u1; bit u2; bit pcsel; bit ebrk;
  } instr_t;

  typedef struct {
    bit stall; bit flush; bit halted; int fa; int fb; int cnt;
  } exp_t;

  exp_t   sb[$];
  instr_t hist[$];   // hist[k] = what issued k+1 cycles ago (v=0 if nothing)
  int     ebreak_age;
  int     m_cnt, m_fa, m_fb;
  int     n_vec = 0;
  int     n_err = 0;
  instr_t nop;

  function automatic instr_t mk(bit wen, int rd, bit load, bit br, int rs1, int rs2,
                                bit u1, bit u2, bit pcsel, bit ebrk);
    instr_t r;
    r.v = 1; r.wen = wen; r.rd = rd; r.load = load; r.br = br;
    r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.pcsel = pcsel; r.ebrk = ebrk;
    return r;
  endfunction

  function automatic bit writes(instr_t p, int rs, bit use_rs);
    return use_rs && p.v && p.wen && p.rd != 0 && p.rd == rs;
  endfunction

  function automatic int src_sel(instr_t a1, instr_t a2, int rs, bit use_rs);
    if (writes(a1, rs, use_rs)) return 1;
    if (writes(a2, rs, use_rs)) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(nop);
    hist.push_back(nop);
    ebreak_age = -1;
    m_cnt = 0; m_fa = 0; m_fb = 0;
  endtask

  task automatic step(input instr_t in, input bit rst, output bit issued);
    exp_t e;
    bit   running, near, far, haz;
    @(posedge sys_clk);
    #1;
    sys_rst      = rst;
    id_valid     = in.v;
    id_wen       = in.wen;
    id_rd        = in.rd[4:0];
    id_is_load   = in.load;
    id_is_branch = in.br;
    id_rs1       = in.rs1[4:0];
    id_rs2       = in.rs2[4:0];
    id_use_rs1   = in.u1;
    id_use_rs2   = in.u2;
    id_pc_sel    = in.pcsel;
    id_ebreak    = in.ebrk;
    issued = 0;
    if (rst) begin
      model_reset();
      e.stall = 0; e.flush = 0; e.halted = 0; e.fa = 0; e.fb = 0; e.cnt = 0;
      sb.push_back(e);
    end else begin
      running = (ebreak_age < 0);
      near = writes(hist[0], in.rs1, in.u1) || writes(hist[0], in.rs2, in.u2);
      far  = writes(hist[1], in.rs1, in.u1) || writes(hist[1], in.rs2, in.u2);
`ifdef HAZARD_FORWARD_EN
      haz = in.v && ((in.br && (near || far)) || (hist[0].load && near));
`else
      haz = in.v && (near || far);
`endif
      e.stall  = !running || haz;
      e.flush  = running && in.v && in.pcsel && !haz;
      e.halted = (ebreak_age >= 4);
      e.fa = m_fa; e.fb = m_fb; e.cnt = m_cnt;
      sb.push_back(e);
      issued = running && in.v && !haz;
      if (running && haz && m_cnt < CNT_MAX) m_cnt++;
`ifdef HAZARD_FORWARD_EN
      m_fa = issued ? src_sel(hist[0], hist[1], in.rs1, in.u1) : 0;
      m_fb = issued ? src_sel(hist[0], hist[1], in.rs2, in.u2) : 0;
`else
      m_fa = 0; m_fb = 0;
`endif
      hist.push_front(issued ? in : nop);
      void'(hist.pop_back());
      if (ebreak_age >= 0) ebreak_age++;
      else if (issued && in.ebrk) ebreak_age = 1;
    end
  endtask

  task automatic issue(input instr_t in);
    bit iss;
    int k;
    iss = 0; k = 0;
    while (!iss && k < 8) begin
      step(in, 0, iss);
      k++;
    end
    if (!iss) begin
      n_err++;
      $display("FAIL issue_timeout: instruction rd=%0d not issued after %0d cycles, required issue", in.rd, k);
    end
  endtask

  task automatic idle(input int n);
    bit iss;
    for (int i = 0; i < n; i++) step(nop, 0, iss);
  endtask

  function automatic instr_t rand_instr();
    instr_t r;
    r.v = ($urandom_range(0, 3) != 0);
    r.wen = $urandom_range(0, 1); r.rd = $urandom_range(0, 3);
    r.load = ($urandom_range(0, 2) == 0); r.br = ($urandom_range(0, 3) == 0);
    r.rs1 = $urandom_range(0, 3); r.rs2 = $urandom_range(0, 3);
    r.u1 = $urandom_range(0, 1); r.u2 = $urandom_range(0, 1);
    r.pcsel = $urandom_range(0, 1); r.ebrk = 0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, required %0d", nm, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        chk("stall_if",  32'(stall_if),  32'(e.stall));
        chk("stall_id",  32'(stall_id),  32'(e.stall));
        chk("bubble_ex", 32'(bubble_ex), 32'(e.stall));
        chk("flush_id",  32'(flush_id),  32'(e.flush));
        chk("halted",    32'(halted),    32'(e.halted));
        chk("fwd_a_sel", 32'(fwd_a_sel), 32'(e.fa));
        chk("fwd_b_sel", 32'(fwd_b_sel), 32'(e.fb));
        chk("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin : stimulus
    bit     iss;
    int     k;
    instr_t in;
    nop = '{default: 0};
    sys_rst = 1; id_valid = 0; id_wen = 0; id_rd = 0; id_is_load = 0; id_is_branch = 0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_pc_sel = 0; id_ebreak = 0;
    model_reset();
    step(nop, 1, iss);
    step(nop, 1, iss);
    idle(1);

    // add x5 ; add x6,x5,x1
    issue(mk(1, 5, 0, 0, 1, 2, 1, 1, 0, 0));
    issue(mk(1, 6, 0, 0, 5, 1, 1, 1, 0, 0));
    idle(3);
    // ld x7 ; add x8,x7,x7
    issue(mk(1, 7, 1, 0, 1, 0, 1, 0, 0, 0));
    issue(mk(1, 8, 0, 0, 7, 7, 1, 1, 0, 0));
    idle(3);
    // addi x9 ; beq x9,x0 taken (pc_sel held high through the stall)
    issue(mk(1, 9, 0, 0, 3, 0, 1, 0, 0, 0));
    issue(mk(0, 0, 0, 1, 9, 0, 1, 1, 1, 0));
    idle(3);
    // write x0 ; read x0
    issue(mk(1, 0, 0, 0, 1, 2, 1, 1, 0, 0));
    issue(mk(1, 10, 0, 0, 0, 0, 1, 1, 0, 0));
    idle(3);

    for (int i = 0; i < 400; i++) begin
      in = rand_instr();
      iss = 0; k = 0;
      do begin
        step(in, 0, iss);
        in.pcsel = $urandom_range(0, 1);
        k++;
      end while (in.v && !iss && k < 8);
      if (in.v && !iss) begin
        n_err++;
        $display("FAIL issue_timeout: random instruction not issued after %0d cycles, required issue", k);
      end
    end
    idle(3);

    // ebreak -> drain -> halt, with live traffic offered to ID
    issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 7; i++) step(rand_instr(), 0, iss);
    step(nop, 1, iss);
    issue(mk(1, 11, 0, 0, 1, 2, 1, 1, 1, 0));
    idle(2);
    // reset in the middle of drain
    issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    idle(2);
    step(nop, 1, iss);
    issue(mk(1, 12, 1, 0, 1, 2, 1, 1, 0, 0));
    issue(mk(1, 13, 0, 0, 12, 0, 1, 0, 0, 0));
    idle(3);

    k = 0;
    while (sb.size() > 0 && k < 10) begin
      @(negedge sys_clk);
      k++;
    end
    @(posedge sys_clk);
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
